// File: rtl/ones_complement_accumulator_if.sv
// Word-in / result-out handshake bundle for the ones' complement accumulator.
// slave = engine side, master = producer/consumer side.
interface ones_complement_accumulator_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] IN_DATA;
   logic             IN_VALID;
   logic             IN_LAST;
   logic             IN_READY;
   logic [WIDTH-1:0] OUT_DATA;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [CNT_W-1:0] OUT_COUNT;

   modport slave (
      input  IN_DATA, IN_VALID, IN_LAST, OUT_READY,
      output IN_READY, OUT_DATA, OUT_VALID, OUT_COUNT
   );

   modport master (
      output IN_DATA, IN_VALID, IN_LAST, OUT_READY,
      input  IN_READY, OUT_DATA, OUT_VALID, OUT_COUNT
   );
endinterface

// File: rtl/ones_complement_accumulator.sv
// Streaming ones' complement summer: end-around-carry accumulate, fold guard bits, hold result until taken.
// Last beat -> OUT_VALID in 2..4 cycles; IN_READY low outside ACCUM. OCSUM_INVERT_EN selects inverted (checksum) output.
module ones_complement_accumulator #(
   parameter int WIDTH = 16,
   parameter int GUARD = 4,
   parameter int CNT_W = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic CLEAR,
   ones_complement_accumulator_if.slave bus
);

   localparam int AW = WIDTH + GUARD;

   typedef enum logic [1:0] {
      S_ACCUM = 2'd0,
      S_FOLD  = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    w_acc_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] w_out_data_nxt;
   logic [CNT_W-1:0] r_out_count;
   logic [CNT_W-1:0] w_out_count_nxt;
   logic             r_out_vld;
   logic             w_out_vld_nxt;

   logic [WIDTH-1:0] w_lo;
   logic [GUARD-1:0] w_hi;
   logic [AW-1:0]    w_lo_plus_hi;
   logic [AW-1:0]    w_acc_add;
   logic [WIDTH-1:0] w_result;
   logic             w_accept;
   logic             w_count_sat;

   assign w_lo         = r_acc[WIDTH-1:0];
   assign w_hi         = r_acc[AW-1:WIDTH];
   assign w_lo_plus_hi = AW'(w_lo) + AW'(w_hi);
   // lo + hi + word stays below 2^AW whenever GUARD >= 2, so no carry is lost
   assign w_acc_add    = w_lo_plus_hi + AW'(bus.IN_DATA);
   assign w_accept     = bus.IN_VALID && (r_state == S_ACCUM);
   assign w_count_sat  = &r_count;

`ifdef OCSUM_INVERT_EN
   assign w_result = ~w_lo;
`else
   assign w_result = w_lo;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_count_nxt     = r_count;
      w_out_data_nxt  = r_out_data;
      w_out_count_nxt = r_out_count;
      w_out_vld_nxt   = r_out_vld;

      if (CLEAR) begin
         w_state_nxt   = S_ACCUM;
         w_acc_nxt     = '0;
         w_count_nxt   = '0;
         w_out_vld_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ACCUM: begin
               if (w_accept) begin
                  w_acc_nxt = w_acc_add;
                  if (!w_count_sat) begin
                     w_count_nxt = r_count + CNT_W'(1);
                  end
                  if (bus.IN_LAST) begin
                     w_state_nxt = S_FOLD;
                  end
               end
            end
            S_FOLD: begin
               if (w_hi == '0) begin
                  w_out_data_nxt  = w_result;
                  w_out_count_nxt = r_count;
                  w_out_vld_nxt   = 1'b1;
                  w_state_nxt     = S_OUT;
               end else begin
                  w_acc_nxt = w_lo_plus_hi;
               end
            end
            S_OUT: begin
               if (bus.OUT_READY) begin
                  w_acc_nxt     = '0;
                  w_count_nxt   = '0;
                  w_out_vld_nxt = 1'b0;
                  w_state_nxt   = S_ACCUM;
               end
            end
            default: begin
               w_state_nxt   = S_ACCUM;
               w_acc_nxt     = '0;
               w_count_nxt   = '0;
               w_out_vld_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_ACCUM;
         r_acc       <= '0;
         r_count     <= '0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_vld   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_count     <= w_count_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_count <= w_out_count_nxt;
         r_out_vld   <= w_out_vld_nxt;
      end
   end

   assign bus.IN_READY  = (r_state == S_ACCUM);
   assign bus.OUT_DATA  = r_out_data;
   assign bus.OUT_COUNT = r_out_count;
   assign bus.OUT_VALID = r_out_vld;

`ifndef SYNTHESIS
   // a presented result must not move until the consumer takes it
   a_out_hold: assert property (@(posedge CLK) disable iff (!RST_N)
      (r_state == S_OUT && !bus.OUT_READY && !CLEAR) |=>
      (r_out_vld && $stable(r_out_data) && $stable(r_out_count)));

   a_vld_state: assert property (@(posedge CLK) disable iff (!RST_N)
      r_out_vld == (r_state == S_OUT));
`endif

endmodule

// File: tb/tb_ones_complement_accumulator.sv
// Directed table plus corner sequences for the ones' complement accumulator (16-bit and 8-bit/CNT_W=4 instances).
module tb_ones_complement_accumulator;
`ifdef OCSUM_INVERT_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST_N;
   logic CLEAR;
   int   checks = 0;
   int   errors = 0;

   ones_complement_accumulator_if #(.WIDTH(16), .CNT_W(16)) bus16 ();
   ones_complement_accumulator_if #(.WIDTH(8),  .CNT_W(4))  bus8 ();

   ones_complement_accumulator #(.WIDTH(16), .GUARD(4), .CNT_W(16)) u_dut16 (
      .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .bus(bus16)
   );
   ones_complement_accumulator #(.WIDTH(8), .GUARD(4), .CNT_W(4)) u_dut8 (
      .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .bus(bus8)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] w [4];
      int          n;
      logic [15:0] exp_d;
      int          exp_c;
      int          exp_lat;
   } vec_t;

   vec_t vt [6];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] fin16(input logic [15:0] x);
      return INV ? ~x : x;
   endfunction

   function automatic logic [7:0] fin8(input logic [7:0] x);
      return INV ? ~x : x;
   endfunction

   function automatic logic [15:0] model16(input logic [15:0] q [$]);
      logic [16:0] s = '0;
      foreach (q[i]) begin
         s = {1'b0, s[15:0]} + {1'b0, q[i]};
         if (s[16]) s = {1'b0, s[15:0]} + 17'd1;
      end
      return s[15:0];
   endfunction

   function automatic logic [7:0] model8(input logic [7:0] q [$]);
      logic [8:0] s = '0;
      foreach (q[i]) begin
         s = {1'b0, s[7:0]} + {1'b0, q[i]};
         if (s[8]) s = {1'b0, s[7:0]} + 9'd1;
      end
      return s[7:0];
   endfunction

   task automatic send16(input logic [15:0] q [$], input bit rnd, input bit last_en);
      for (int i = 0; i < q.size(); i++) begin
         bit done = 1'b0;
         int tries = 0;
         while (!done) begin
            bus16.IN_DATA  = q[i];
            bus16.IN_LAST  = last_en && (i == q.size() - 1);
            bus16.IN_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = bus16.IN_VALID && bus16.IN_READY;
            tick();
            tries++;
            if (tries > 50) begin
               chk("send16_ready", bus16.IN_READY, 1);
               bus16.IN_VALID = 1'b0;
               return;
            end
         end
      end
      bus16.IN_VALID = 1'b0;
      bus16.IN_LAST  = 1'b0;
   endtask

   task automatic wait_valid16(output int lat);
      lat = 1;
      while (!bus16.OUT_VALID && lat < 10) begin
         tick();
         lat++;
      end
      chk("out16_valid_seen", bus16.OUT_VALID, 1);
   endtask

   task automatic take16(input bit rnd);
      bit hs = 1'b0;
      int n = 0;
      while (!hs && n < 40) begin
         bus16.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = bus16.OUT_READY && bus16.OUT_VALID;
         tick();
         n++;
      end
      bus16.OUT_READY = 1'b0;
      chk("out16_valid_drop", bus16.OUT_VALID, 0);
   endtask

   task automatic run_pkt16(input string tag, input logic [15:0] q [$], input bit rnd,
                            input logic [15:0] exp_d, input int exp_c, input int exp_lat);
      int lat;
      send16(q, rnd, 1'b1);
      wait_valid16(lat);
      if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_data"}, bus16.OUT_DATA, exp_d);
      chk({tag, "_count"}, bus16.OUT_COUNT, exp_c);
      take16(rnd);
   endtask

   task automatic run_pkt8(input string tag, input int n);
      logic [7:0] q [$];
      int lat = 0;
      bit hs = 1'b0;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < n; i++) begin
         bit done = 1'b0;
         while (!done) begin
            bus8.IN_DATA  = q[i];
            bus8.IN_LAST  = (i == n - 1);
            bus8.IN_VALID = 1'($urandom_range(0, 1));
            done = bus8.IN_VALID && bus8.IN_READY;
            tick();
         end
      end
      bus8.IN_VALID = 1'b0;
      bus8.IN_LAST  = 1'b0;
      while (!bus8.OUT_VALID && lat < 10) begin
         tick();
         lat++;
      end
      chk({tag, "_valid_seen"}, bus8.OUT_VALID, 1);
      chk({tag, "_data"}, bus8.OUT_DATA, fin8(model8(q)));
      chk({tag, "_count"}, bus8.OUT_COUNT, (n > 15) ? 15 : n);
      for (int k = 0; k < 40 && !hs; k++) begin
         bus8.OUT_READY = 1'($urandom_range(0, 1));
         hs = bus8.OUT_READY && bus8.OUT_VALID;
         tick();
      end
      bus8.OUT_READY = 1'b0;
      chk({tag, "_valid_drop"}, bus8.OUT_VALID, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [15:0] q [$];
      int lat;

      RST_N = 1'b0;
      CLEAR = 1'b0;
      bus16.IN_DATA = '0; bus16.IN_VALID = 1'b0; bus16.IN_LAST = 1'b0; bus16.OUT_READY = 1'b0;
      bus8.IN_DATA  = '0; bus8.IN_VALID  = 1'b0; bus8.IN_LAST  = 1'b0; bus8.OUT_READY  = 1'b0;

      vt[0] = '{w: '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000}, n: 2, exp_d: 16'h0001, exp_c: 2, exp_lat: 3};
      vt[1] = '{w: '{16'h8000, 16'h8000, 16'h8000, 16'h0000}, n: 3, exp_d: 16'h8001, exp_c: 3, exp_lat: 2};
      vt[2] = '{w: '{16'h1234, 16'hEDCB, 16'h0000, 16'h0000}, n: 2, exp_d: 16'hFFFF, exp_c: 2, exp_lat: 2};
      vt[3] = '{w: '{16'h0005, 16'h0000, 16'h0000, 16'h0000}, n: 1, exp_d: 16'h0005, exp_c: 1, exp_lat: 2};
      vt[4] = '{w: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, n: 1, exp_d: 16'h0000, exp_c: 1, exp_lat: 2};
      vt[5] = '{w: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, n: 4, exp_d: 16'hFFFF, exp_c: 4, exp_lat: 3};

      tick();
      tick();
      RST_N = 1'b1;
      tick();
      chk("rst_in_ready", bus16.IN_READY, 1);
      chk("rst_out_valid", bus16.OUT_VALID, 0);
      chk("rst_out_data", bus16.OUT_DATA, 0);
      chk("rst_out_count", bus16.OUT_COUNT, 0);
      chk("rst8_out_valid", bus8.OUT_VALID, 0);

      for (int v = 0; v < 6; v++) begin
         q.delete();
         for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].w[i]);
         run_pkt16($sformatf("vec%0d", v), q, 1'b0, fin16(vt[v].exp_d), vt[v].exp_c, vt[v].exp_lat);
      end

      // backpressure: result held, input refused, then next word taken right after handshake
      q.delete(); q.push_back(16'h0003); q.push_back(16'h0004);
      send16(q, 1'b0, 1'b1);
      wait_valid16(lat);
      chk("bp_latency", lat, 2);
      bus16.IN_DATA = 16'h0010; bus16.IN_LAST = 1'b1; bus16.IN_VALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_in_ready_c%0d", c), bus16.IN_READY, 0);
         chk($sformatf("bp_out_data_c%0d", c), bus16.OUT_DATA, fin16(16'h0007));
         chk($sformatf("bp_out_valid_c%0d", c), bus16.OUT_VALID, 1);
         tick();
      end
      chk("bp_out_count", bus16.OUT_COUNT, 2);
      bus16.OUT_READY = 1'b1;
      tick();
      bus16.OUT_READY = 1'b0;
      chk("bp_ready_after", bus16.IN_READY, 1);
      tick();
      bus16.IN_VALID = 1'b0; bus16.IN_LAST = 1'b0;
      wait_valid16(lat);
      chk("bp_next_latency", lat, 2);
      chk("bp_next_data", bus16.OUT_DATA, fin16(16'h0010));
      chk("bp_next_count", bus16.OUT_COUNT, 1);
      take16(1'b0);

      // reset while folding
      q.delete(); q.push_back(16'h1111);
      send16(q, 1'b0, 1'b1);
      RST_N = 1'b0;
      #1;
      chk("fold_rst_out_valid", bus16.OUT_VALID, 0);
      chk("fold_rst_out_count", bus16.OUT_COUNT, 0);
      chk("fold_rst_out_data", bus16.OUT_DATA, 0);
      tick();
      RST_N = 1'b1;
      tick(); tick(); tick();
      chk("fold_rst_no_result", bus16.OUT_VALID, 0);
      chk("fold_rst_in_ready", bus16.IN_READY, 1);

      // CLEAR after three beats of an unfinished packet
      q.delete(); q.push_back(16'h0100); q.push_back(16'h0200); q.push_back(16'h0300);
      send16(q, 1'b0, 1'b0);
      CLEAR = 1'b1;
      tick();
      CLEAR = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("clr_no_valid_c%0d", c), bus16.OUT_VALID, 0);
         tick();
      end
      q.delete(); q.push_back(16'h0005);
      run_pkt16("clr_next", q, 1'b0, fin16(16'h0005), 1, 2);

      // CLEAR drops a presented result
      q.delete(); q.push_back(16'h0009);
      send16(q, 1'b0, 1'b1);
      wait_valid16(lat);
      CLEAR = 1'b1;
      tick();
      CLEAR = 1'b0;
      chk("clr_out_dropped", bus16.OUT_VALID, 0);
      chk("clr_out_in_ready", bus16.IN_READY, 1);
      q.delete(); q.push_back(16'h0002); q.push_back(16'h0003);
      run_pkt16("clr_out_next", q, 1'b0, fin16(16'h0005), 2, 2);

      // random packets, random valid/ready, 16-bit
      for (int p = 0; p < 5; p++) begin
         int n = $urandom_range(1, 300);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 65535)));
         run_pkt16($sformatf("rnd16_p%0d", p), q, 1'b1, fin16(model16(q)), n, 0);
      end

      // 8-bit engine with a 4-bit saturating beat counter
      run_pkt8("w8_n20", 20);
      run_pkt8("w8_n1", 1);
      run_pkt8("w8_n15", 15);
      run_pkt8("w8_n16", 16);
      for (int p = 0; p < 3; p++) run_pkt8($sformatf("w8_rnd%0d", p), $urandom_range(1, 300));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
